// File: rtl/room_disp_pkg.sv
// Shared constants for the room-number display path: active-low segment
// patterns {g,f,e,d,c,b,a}, active-low anode enables {tens,ones}, digit select.
package room_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [1:0] ANODE_OFF  = 2'b11;
  localparam logic [1:0] ANODE_ONES = 2'b10;
  localparam logic [1:0] ANODE_TENS = 2'b01;

  typedef enum logic {
    SEL_ONES = 1'b0,
    SEL_TENS = 1'b1
  } sel_e;

endpackage

// File: rtl/bcd_seven_seg.sv
// BCD to active-low seven-segment decoder; codes 10..15 show a dash so a
// corrupt counter value is visible rather than silently wrong.
module bcd_seven_seg
  import room_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/room_display_scan.sv
// Latches the two-digit room number and scans it onto a common-anode display,
// with leading-zero blanking, edit-mode blinking and a bad-digit flag.
module room_display_scan
  import room_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_SCANS = 250
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] RoomDigit1,
  input  logic [3:0] RoomDigit0,
  input  logic       Load,
  input  logic       Blink,
  input  logic       BlankLz,
  output logic [6:0] Segments,
  output logic [1:0] Anodes,
  output logic       BadDigit
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SCANS - 1);

  logic [3:0]    lat1_q, lat1_d, lat0_q, lat0_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  sel_e          sel_q, sel_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    anode_q, anode_d;
  logic          bad_q, bad_d;

  logic          scan_tc;
  logic [3:0]    shown_digit;
  logic [6:0]    shown_seg;
  logic          tens_blank;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lat1_q      <= '0;
      lat0_q      <= '0;
      ref_cnt_q   <= '0;
      sel_q       <= SEL_ONES;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      seg_q       <= SEG_OFF;
      anode_q     <= ANODE_OFF;
      bad_q       <= 1'b0;
    end else begin
      lat1_q      <= lat1_d;
      lat0_q      <= lat0_d;
      ref_cnt_q   <= ref_cnt_d;
      sel_q       <= sel_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      anode_q     <= anode_d;
      bad_q       <= bad_d;
    end
  end

  always_comb begin
    lat1_d = lat1_q;
    lat0_d = lat0_q;
    if (Load) begin
      lat1_d = RoomDigit1;
      lat0_d = RoomDigit0;
    end
  end

  assign scan_tc = (ref_cnt_q == REF_LAST);

  always_comb begin
    ref_cnt_d = scan_tc ? '0 : ref_cnt_q + RW'(1);
    sel_d     = sel_q;
    if (scan_tc) sel_d = (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
  end

  // Blink timing restarts from zero each time edit mode is entered.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!Blink) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (scan_tc) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  assign shown_digit = (sel_q == SEL_TENS) ? lat1_q : lat0_q;

  bcd_seven_seg u_dec (
    .bcd (shown_digit),
    .seg (shown_seg)
  );

  // Only a true zero is blanked; a dash in the tens place stays visible.
  assign tens_blank = BlankLz && (lat1_q == 4'd0);

  always_comb begin
    seg_d   = shown_seg;
    anode_d = (sel_q == SEL_TENS) ? ANODE_TENS : ANODE_ONES;
    if ((Blink && phase_q) || ((sel_q == SEL_TENS) && tens_blank)) begin
      seg_d   = SEG_OFF;
      anode_d = ANODE_OFF;
    end
    bad_d = (lat1_q > 4'd9) || (lat0_q > 4'd9);
  end

  assign Segments = seg_q;
  assign Anodes   = anode_q;
  assign BadDigit = bad_q;

endmodule

// File: tb/tb_room_display_scan.sv
// Bench for room_display_scan: directed table of latched digit pairs, blink and
// reset sequences, and random stimulus against a cycle-count reference model.
module tb_room_display_scan;

  localparam int RD = 4;
  localparam int BS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] d1 = '0, d0 = '0;
  logic       load = 1'b0, blink = 1'b0, blz = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       bad;

  room_display_scan #(.REFRESH_DIV(RD), .BLINK_SCANS(BS)) dut (
    .Clock      (clk),
    .Resetn     (rst_n),
    .RoomDigit1 (d1),
    .RoomDigit0 (d0),
    .Load       (load),
    .Blink      (blink),
    .BlankLz    (blz),
    .Segments   (seg),
    .Anodes     (an),
    .BadDigit   (bad)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seg_tab [16];

  // Reference model: cycles since reset, blink-mode scan toggles, latched digits.
  int m_t, m_tog, m_lat1, m_lat0, last_sel;

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d0;
    logic       blz;
    logic [6:0] ones_seg;
    logic [1:0] tens_an;
    logic [6:0] tens_seg;
    logic       bad;
  } vec_t;

  vec_t tv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input int d);
    return seg_tab[d[3:0]];
  endfunction

  task automatic tick();
    int sel, ph;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_bad;
    sel   = (m_t / RD) % 2;
    ph    = (m_tog / BS) % 2;
    e_bad = (m_lat1 > 9) || (m_lat0 > 9);
    if (blink && ph == 1) begin
      e_seg = 7'h7f; e_an = 2'b11;
    end else if (sel == 0) begin
      e_seg = dec(m_lat0); e_an = 2'b10;
    end else if (blz && m_lat1 == 0) begin
      e_seg = 7'h7f; e_an = 2'b11;
    end else begin
      e_seg = dec(m_lat1); e_an = 2'b01;
    end
    @(posedge clk); #1;
    check("model_seg", 32'(seg), 32'(e_seg));
    check("model_an", 32'(an), 32'(e_an));
    check("model_bad", 32'(bad), 32'(e_bad));
    if (blink) begin
      if (m_t % RD == RD - 1) m_tog++;
    end else begin
      m_tog = 0;
    end
    m_t++;
    if (load) begin
      m_lat1 = int'(d1);
      m_lat0 = int'(d0);
    end
    last_sel = sel;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_seg", 32'(seg), 32'h7f);
    check("rst_async_an", 32'(an), 32'h3);
    check("rst_async_bad", 32'(bad), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_seg", 32'(seg), 32'h7f);
    check("rst_hold_an", 32'(an), 32'h3);
    @(negedge clk);
    rst_n  = 1'b1;
    m_t    = 0;
    m_tog  = 0;
    m_lat1 = 0;
    m_lat0 = 0;
  endtask

  task automatic latch(input logic [3:0] a, input logic [3:0] b);
    d1 = a; d0 = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int q[$];
    logic hist [48];
    int found;

    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    tv[0] = '{4'd4,  4'd7,  1'b0, 7'b1111000, 2'b01, 7'b0011001, 1'b0};
    tv[1] = '{4'd0,  4'd5,  1'b1, 7'b0010010, 2'b11, 7'b1111111, 1'b0};
    tv[2] = '{4'd1,  4'd0,  1'b1, 7'b1000000, 2'b01, 7'b1111001, 1'b0};
    tv[3] = '{4'd12, 4'd3,  1'b1, 7'b0110000, 2'b01, 7'b0111111, 1'b1};
    tv[4] = '{4'd9,  4'd9,  1'b0, 7'b0010000, 2'b01, 7'b0010000, 1'b0};
    tv[5] = '{4'd0,  4'd0,  1'b0, 7'b1000000, 2'b01, 7'b1000000, 1'b0};
    tv[6] = '{4'd15, 4'd10, 1'b1, 7'b0111111, 2'b01, 7'b0111111, 1'b1};
    tv[7] = '{4'd0,  4'd11, 1'b1, 7'b0111111, 2'b11, 7'b1111111, 1'b1};

    do_reset();

    // Idle scan after reset: ones then tens, both showing zero.
    for (int k = 0; k < 2 * RD; k++) begin
      tick();
      check("post_rst_an", 32'(an), (k < RD) ? 32'h2 : 32'h1);
      check("post_rst_seg", 32'(seg), 32'h40);
    end

    // Table: latch a pair, scramble the inputs with Load low, then check a full scan.
    for (int i = 0; i < 8; i++) begin
      blz = tv[i].blz;
      latch(tv[i].d1, tv[i].d0);
      d1 = 4'($urandom_range(15));
      d0 = 4'($urandom_range(15));
      tick();
      for (int k = 0; k < 2 * RD; k++) begin
        tick();
        if (last_sel == 0) begin
          check("tab_ones_an", 32'(an), 32'h2);
          check("tab_ones_seg", 32'(seg), 32'(tv[i].ones_seg));
        end else begin
          check("tab_tens_an", 32'(an), 32'(tv[i].tens_an));
          check("tab_tens_seg", 32'(seg), 32'(tv[i].tens_seg));
        end
        check("tab_bad", 32'(bad), 32'(tv[i].bad));
      end
    end

    // Blink: every complete blank or lit run lasts BS half-scans.
    blz = 1'b0;
    latch(4'd8, 4'd8);
    repeat (3) tick();
    blink = 1'b1;
    for (int k = 0; k < 48; k++) begin
      tick();
      hist[k] = (an == 2'b11);
    end
    for (int k = 1; k < 48; k++)
      if (hist[k] != hist[k-1]) q.push_back(k);
    check("blink_transitions", 32'(q.size() >= 3), 32'h1);
    for (int j = 1; j < q.size(); j++)
      check("blink_run_len", 32'(q[j] - q[j-1]), 32'(BS * RD));

    // Drop Blink during a blank phase: the very next update is lit.
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      tick();
      if (an == 2'b11) found = 1;
    end
    check("blank_phase_found", 32'(found), 32'h1);
    blink = 1'b0;
    tick();
    check("unblink_an", 32'(an), (last_sel == 0) ? 32'h2 : 32'h1);
    check("unblink_seg", 32'(seg), 32'h00);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      load = ($urandom_range(3) == 0);
      d1   = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
      d0   = 4'($urandom_range(15));
      if ($urandom_range(19) == 0) blink = ~blink;
      if ($urandom_range(29) == 0) blz = ~blz;
      tick();
    end
    load = 1'b0;

    // Reset mid-scan while blinking with 8/8 latched.
    blz = 1'b0;
    blink = 1'b1;
    latch(4'd8, 4'd8);
    repeat (5) tick();
    do_reset();
    for (int k = 0; k < RD + 1; k++) begin
      tick();
      check("rst2_an", 32'(an), (k < RD) ? 32'h2 : 32'h1);
      check("rst2_seg", 32'(seg), 32'h40);
    end
    blink = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
